// File: rtl/mycpu_pkg.sv
// mycpu_pkg
//   Shared constants and helpers for the SRAM-like channel logic in the core.
//   Contents:
//     SRAM_TRACKER_DEPTH_DEFAULT - default outstanding-request limit of a tracker
//     SRAM_TRACKER_DROP_W        - width of the dropped-response statistic
//     cnt_w(depth)               - bits needed to hold a count in 0..depth
package mycpu_pkg;

  localparam int SRAM_TRACKER_DEPTH_DEFAULT = 4;
  localparam int SRAM_TRACKER_DROP_W        = 16;

  // A count that can reach 'depth' itself needs one more code than depth-1.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_resp_tracker_sat_counter.sv
// sat_counter
//   Saturating up-counter with synchronous clear. It sticks at all-ones
//   instead of wrapping, so a statistic never falls back to a small value.
// Parameters:
//   W        counter width
// Ports:
//   clk      in   clock
//   resetn   in   asynchronous active-low reset, clears the count
//   i_inc    in   add one this cycle (ignored once saturated)
//   i_clr    in   synchronous clear, wins over i_inc
//   o_count  out  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count register: clear has priority, and increments stop at all-ones.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sram_resp_tracker.sv
// sram_resp_tracker
//   Outstanding-request tracker and flush filter for one SRAM-like
//   request/response channel between a pipeline stage and the AXI bridge.
//   Counts accepted-but-unanswered requests, stops issuing at DEPTH, and
//   after a pipeline flush swallows the responses of requests that were in
//   flight so stale data never reaches the pipeline.
// Optional feature:
//   SRAM_TRACKER_STATS_EN - when defined, adds the drop_cnt port: a saturating
//   count of every discarded response (stale and protocol-error ones).
// Parameters:
//   DEPTH  maximum outstanding requests (1..15)
//   DW     read-data width
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   up_req                 in   request from the pipeline stage
//   up_addr_ok             out  address handshake toward the pipeline
//   up_data_ok             out  valid, non-stale response toward the pipeline
//   up_rdata               out  response data (pass-through)
//   sram_req               out  request toward the bridge
//   sram_addr_ok           in   bridge address handshake
//   sram_data_ok           in   bridge response strobe, in-order responses
//   sram_rdata             in   bridge response data
//   flush                  in   one-cycle pipeline flush
//   outstanding            out  in-flight request count
//   full                   out  outstanding == DEPTH
//   waiting                out  outstanding != 0
//   proto_err              out  sticky: response seen with nothing in flight
//   drop_cnt               out  discarded-response count (stats builds only)
module sram_resp_tracker
  import mycpu_pkg::*;
#(
  parameter  int DEPTH = SRAM_TRACKER_DEPTH_DEFAULT,
  parameter  int DW    = 32,
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          up_req,
  output logic          up_addr_ok,
  output logic          up_data_ok,
  output logic [DW-1:0] up_rdata,
  output logic          sram_req,
  input  logic          sram_addr_ok,
  input  logic          sram_data_ok,
  input  logic [DW-1:0] sram_rdata,
  input  logic          flush,
  output logic [CW-1:0] outstanding,
  output logic          full,
  output logic          waiting,
  output logic          proto_err
`ifdef SRAM_TRACKER_STATS_EN
  ,
  output logic [SRAM_TRACKER_DROP_W-1:0] drop_cnt
`endif
);

  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic          r_proto_err;

  logic          w_full;
  logic          w_busy;
  logic          w_issue;
  logic          w_retire;
  logic          w_forward;
  logic [CW-1:0] w_outstanding_next;
  logic [CW-1:0] w_discard_next;

  // full is decoded from the registered count only, so no combinational path
  // runs from sram_data_ok to sram_req.
  assign w_full   = (r_outstanding == CW'(DEPTH));
  assign w_busy   = (r_outstanding != '0);

  // No new request during flush: it belongs to the squashed instruction.
  assign sram_req   = up_req & ~w_full & ~flush;
  assign up_addr_ok = sram_addr_ok & sram_req;
  assign w_issue    = sram_req & sram_addr_ok;

  // A response with nothing in flight is a protocol error, not a retire.
  assign w_retire   = sram_data_ok & w_busy;

  // A response in the flush cycle itself is already stale, whatever discard
  // held before.
  assign w_forward  = w_retire & (r_discard == '0) & ~flush;

  assign up_data_ok = w_forward;
  assign up_rdata   = sram_rdata;

  assign outstanding = r_outstanding;
  assign full        = w_full;
  assign waiting     = w_busy;
  assign proto_err   = r_proto_err;

  // Next-state for both counters. On flush every request still in flight
  // after this cycle is stale; issue is blocked during flush, so that is
  // exactly outstanding - retire, which re-marks rather than accumulates.
  always_comb begin
    w_outstanding_next = r_outstanding + CW'(w_issue) - CW'(w_retire);
    w_discard_next     = r_discard;
    if (flush) begin
      w_discard_next = r_outstanding - CW'(w_retire);
    end else if (w_retire && (r_discard != '0)) begin
      w_discard_next = r_discard - CW'(1);
    end
  end

  // Tracking state: counts, stale marker and the sticky protocol-error flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outstanding <= '0;
      r_discard     <= '0;
      r_proto_err   <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_next;
      r_discard     <= w_discard_next;
      if (sram_data_ok && !w_busy) begin
        r_proto_err <= 1'b1;
      end
    end
  end

`ifdef SRAM_TRACKER_STATS_EN
  // Every response the bridge delivers that is not forwarded is a drop,
  // including the ones that raise proto_err.
  logic w_drop;
  assign w_drop = sram_data_ok & ~w_forward;

  sat_counter #(
    .W(SRAM_TRACKER_DROP_W)
  ) u_drop_cnt (
    .clk     (clk),
    .resetn  (resetn),
    .i_inc   (w_drop),
    .i_clr   (1'b0),
    .o_count (drop_cnt)
  );
`else
  // Statistics build option off: no drop counter.
`endif

endmodule

// File: tb/tb_sram_resp_tracker.sv
// tb_sram_resp_tracker
//   Directed bench for sram_resp_tracker (DEPTH=4, DW=32): backpressure,
//   flush dropping, flush coincident with a response, double flush,
//   protocol error and asynchronous reset. drop_cnt is checked only when
//   SRAM_TRACKER_STATS_EN is defined.
module tb_sram_resp_tracker;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          resetn;
  logic          upReq;
  logic          upAddrOk;
  logic          upDataOk;
  logic [DW-1:0] upRdata;
  logic          sramReq;
  logic          sramAddrOk;
  logic          sramDataOk;
  logic [DW-1:0] sramRdata;
  logic          flushIn;
  logic [CW-1:0] outstandingOut;
  logic          fullOut;
  logic          waitingOut;
  logic          protoErr;
`ifdef SRAM_TRACKER_STATS_EN
  logic [15:0]   dropCnt;
`endif

  int testCount = 0;
  int failCount = 0;
  int expDrop   = 0;

  sram_resp_tracker #(
    .DEPTH(DEPTH),
    .DW   (DW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .up_req       (upReq),
    .up_addr_ok   (upAddrOk),
    .up_data_ok   (upDataOk),
    .up_rdata     (upRdata),
    .sram_req     (sramReq),
    .sram_addr_ok (sramAddrOk),
    .sram_data_ok (sramDataOk),
    .sram_rdata   (sramRdata),
    .flush        (flushIn),
    .outstanding  (outstandingOut),
    .full         (fullOut),
    .waiting      (waitingOut),
    .proto_err    (protoErr)
`ifdef SRAM_TRACKER_STATS_EN
    ,
    .drop_cnt     (dropCnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Drive all inputs, then settle 1 time unit so combinational outputs can
  // be sampled well away from the clock edge.
  task automatic applyStimulus(input logic req, input logic addrOk, input logic dataOk,
                               input logic [31:0] rdata, input logic fl);
    upReq      = req;
    sramAddrOk = addrOk;
    sramDataOk = dataOk;
    sramRdata  = rdata;
    flushIn    = fl;
    #1;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkDrops(input string tag);
`ifdef SRAM_TRACKER_STATS_EN
    checkOutput(tag, 32'(dropCnt), 32'(expDrop));
`endif
  endtask

  // Issue n requests back-to-back with addr_ok always granted.
  task automatic issueN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  // Deliver one response and check whether it reaches the pipeline.
  task automatic respond(input string tag, input logic [31:0] rdata, input logic expFwd);
    applyStimulus(1'b0, 1'b1, 1'b1, rdata, 1'b0);
    checkOutput({tag, "_fwd"}, 32'(upDataOk), 32'(expFwd));
    if (expFwd) checkOutput({tag, "_rdata"}, upRdata, rdata);
    else expDrop++;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2;
    checkOutput("rst_outstanding", 32'(outstandingOut), 32'd0);
    checkOutput("rst_full", 32'(fullOut), 32'd0);
    checkOutput("rst_waiting", 32'(waitingOut), 32'd0);
    checkOutput("rst_proto_err", 32'(protoErr), 32'd0);
    checkOutput("rst_sram_req", 32'(sramReq), 32'd0);
    checkOutput("rst_up_data_ok", 32'(upDataOk), 32'd0);
    checkDrops("rst_drop_cnt");
    #9 resetn = 1'b1;
    nextCycle();

    // Throughput and backpressure.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput($sformatf("tp_req%0d", i), 32'(sramReq), 32'd1);
      checkOutput($sformatf("tp_addr_ok%0d", i), 32'(upAddrOk), 32'd1);
      nextCycle();
      checkOutput($sformatf("tp_out%0d", i), 32'(outstandingOut), 32'(i + 1));
    end
    checkOutput("tp_full", 32'(fullOut), 32'd1);
    checkOutput("tp_req_blocked", 32'(sramReq), 32'd0);
    checkOutput("tp_addr_ok_blocked", 32'(upAddrOk), 32'd0);
    nextCycle();
    checkOutput("tp_hold_out", 32'(outstandingOut), 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    checkOutput("tp_fwd", 32'(upDataOk), 32'd1);
    checkOutput("tp_rdata", upRdata, 32'hDEADBEEF);
    checkOutput("tp_no_issue_when_full", 32'(sramReq), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("tp_out_after_retire", 32'(outstandingOut), 32'd3);
    checkOutput("tp_full_dropped", 32'(fullOut), 32'd0);
    checkOutput("tp_resume", 32'(sramReq), 32'd1);
    nextCycle();
    checkOutput("tp_refill", 32'(outstandingOut), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < DEPTH; i++) respond($sformatf("tp_drain%0d", i), 32'h100 + 32'(i), 1'b1);
    checkOutput("tp_empty", 32'(outstandingOut), 32'd0);
    checkOutput("tp_not_waiting", 32'(waitingOut), 32'd0);

    // Flush drop: three in flight become stale, a post-flush request is served.
    issueN(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("fl_req_blocked", 32'(sramReq), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("fl_issue_next", 32'(sramReq), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("fl_out", 32'(outstandingOut), 32'd4);
    respond("fl_stale1", 32'h1, 1'b0);
    respond("fl_stale2", 32'h2, 1'b0);
    respond("fl_stale3", 32'h3, 1'b0);
    respond("fl_fresh", 32'h1234, 1'b1);
    checkOutput("fl_empty", 32'(outstandingOut), 32'd0);
    checkDrops("fl_drop_cnt");

    // Flush in the same cycle as a response.
    issueN(2);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hAA, 1'b1);
    checkOutput("fc_flush_cycle_drop", 32'(upDataOk), 32'd0);
    expDrop++;
    nextCycle();
    checkOutput("fc_out_mid", 32'(outstandingOut), 32'd1);
    respond("fc_stale", 32'hBB, 1'b0);
    checkOutput("fc_empty", 32'(outstandingOut), 32'd0);
    checkDrops("fc_drop_cnt");

    // Double flush: re-marking must not underflow the stale count.
    issueN(4);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    nextCycle();
    respond("df_stale_a", 32'h10, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("df_out", 32'(outstandingOut), 32'd3);
    respond("df_stale_b", 32'h11, 1'b0);
    respond("df_stale_c", 32'h12, 1'b0);
    respond("df_stale_d", 32'h13, 1'b0);
    checkOutput("df_empty", 32'(outstandingOut), 32'd0);
    issueN(1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h5555, 1'b0);
    checkOutput("df_no_underflow_fwd", 32'(upDataOk), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("df_issue_retire_same", 32'(outstandingOut), 32'd1);
    respond("df_last", 32'h6666, 1'b1);
    checkOutput("df_final_empty", 32'(outstandingOut), 32'd0);
    checkDrops("df_drop_cnt");

    // Protocol error, then asynchronous reset with requests in flight.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h77, 1'b0);
    checkOutput("pe_no_fwd", 32'(upDataOk), 32'd0);
    expDrop++;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pe_flag", 32'(protoErr), 32'd1);
    checkOutput("pe_out", 32'(outstandingOut), 32'd0);
    checkDrops("pe_drop_cnt");
    issueN(2);
    checkOutput("pe_sticky", 32'(protoErr), 32'd1);
    checkOutput("pe_out_before_rst", 32'(outstandingOut), 32'd2);
    resetn = 1'b0;
    #2;
    checkOutput("ar_proto_err", 32'(protoErr), 32'd0);
    checkOutput("ar_outstanding", 32'(outstandingOut), 32'd0);
    expDrop = 0;
    checkDrops("ar_drop_cnt");
    nextCycle();
    resetn = 1'b1;
    nextCycle();
    respond("ar_stale_after_rst", 32'h88, 1'b0);
    checkOutput("ar_proto_again", 32'(protoErr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
